// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher: expands a key into 11 stored round keys,
// then decrypts one block per 10 rounds with a one-cycle completion pulse.
module aes_decryption (
  input  logic         aclk,
  input  logic         areset,
  input  logic [127:0] key,
  input  logic         key_init,
  output logic         key_ready,
  input  logic         next,
  input  logic [127:0] input_block,
  output logic [127:0] output_block,
  output logic         block_ready
);

  typedef enum logic [1:0] {IDLE, KEXP, DEC} fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [3:0]   round_reg, round_next;
  logic [7:0]   rcon_reg, rcon_next;
  logic [127:0] prev_key_reg, prev_key_next;
  logic [127:0] state_reg, state_next;
  logic [127:0] output_reg, output_next;
  logic         key_ready_reg, key_ready_next;
  logic         block_ready_reg, block_ready_next;

  logic [127:0] rk_mem [0:10];
  logic         rk_we;
  logic [3:0]   rk_waddr;
  logic [127:0] rk_wdata;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic [127:0] isr, isb, ark, imc;
  logic [31:0]  rot_word, sub_word;
  logic [127:0] new_rk;

  // Byte k of the state is row k%4 of column k/4; row r rotates right by r.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int COL = gi / 4;
      localparam int ROW = gi % 4;
      localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
      assign isr[127-8*gi -: 8] = state_reg[127-8*SRC -: 8];
      assign isb[127-8*gi -: 8] = inv_sbox(isr[127-8*gi -: 8]);
    end
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign imc[127-32*gi -: 32] = inv_mix_col(ark[127-32*gi -: 32]);
      assign sub_word[31-8*gi -: 8] = sbox(rot_word[31-8*gi -: 8]);
    end
  endgenerate

  assign ark      = isb ^ rk_mem[round_reg];
  assign rot_word = {prev_key_reg[23:0], prev_key_reg[31:24]};

  always_comb begin
    new_rk[127:96] = prev_key_reg[127:96] ^ sub_word ^ {rcon_reg, 24'h000000};
    new_rk[95:64]  = prev_key_reg[95:64] ^ new_rk[127:96];
    new_rk[63:32]  = prev_key_reg[63:32] ^ new_rk[95:64];
    new_rk[31:0]   = prev_key_reg[31:0] ^ new_rk[63:32];
  end

  always_comb begin
    fsm_next         = fsm_reg;
    round_next       = round_reg;
    rcon_next        = rcon_reg;
    prev_key_next    = prev_key_reg;
    state_next       = state_reg;
    output_next      = output_reg;
    key_ready_next   = key_ready_reg;
    block_ready_next = 1'b0;
    rk_we            = 1'b0;
    rk_waddr         = round_reg;
    rk_wdata         = new_rk;
    case (fsm_reg)
      IDLE: begin
        if (key_init) begin
          fsm_next       = KEXP;
          round_next     = 4'd1;
          rcon_next      = 8'h01;
          prev_key_next  = key;
          key_ready_next = 1'b0;
          rk_we          = 1'b1;
          rk_waddr       = 4'd0;
          rk_wdata       = key;
        end else if (next && key_ready_reg) begin
          fsm_next   = DEC;
          round_next = 4'd9;
          state_next = input_block ^ rk_mem[10];
        end
      end
      KEXP: begin
        rk_we         = 1'b1;
        prev_key_next = new_rk;
        rcon_next     = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
        if (round_reg == 4'd10) begin
          fsm_next       = IDLE;
          round_next     = 4'd0;
          key_ready_next = 1'b1;
        end else begin
          round_next = round_reg + 4'd1;
        end
      end
      DEC: begin
        if (round_reg == 4'd0) begin
          fsm_next         = IDLE;
          output_next      = ark;
          block_ready_next = 1'b1;
        end else begin
          state_next = imc;
          round_next = round_reg - 4'd1;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      fsm_reg         <= IDLE;
      round_reg       <= 4'd0;
      rcon_reg        <= 8'h01;
      prev_key_reg    <= 128'd0;
      state_reg       <= 128'd0;
      output_reg      <= 128'd0;
      key_ready_reg   <= 1'b0;
      block_ready_reg <= 1'b0;
    end else begin
      fsm_reg         <= fsm_next;
      round_reg       <= round_next;
      rcon_reg        <= rcon_next;
      prev_key_reg    <= prev_key_next;
      state_reg       <= state_next;
      output_reg      <= output_next;
      key_ready_reg   <= key_ready_next;
      block_ready_reg <= block_ready_next;
    end
  end

  // Validity of the store is tracked by key_ready, so the array needs no reset.
  always_ff @(posedge aclk) begin
    if (rk_we) rk_mem[rk_waddr] <= rk_wdata;
  end

  assign key_ready    = key_ready_reg;
  assign block_ready  = block_ready_reg;
  assign output_block = output_reg;

endmodule
